butterfly2_pipe: RTL and testbench
==================================

# butterfly2_pipe

Fully pipelined, parametrised radix-2 DIT butterfly for the FFT datapath. It computes out0 = in0 + W·in1 and out1 = in0 − W·in1 on signed Qm.Q fixed-point data. It adds a valid/ready handshake with pipeline stall, forward/inverse mode (conjugated twiddle), optional per-stage ÷2 scaling with rounding, output saturation with a sticky overflow flag, and a user tag carried alongside the data. One instance serves one butterfly slot in an FFT stage; the stage controller drives mode and scale.

## Interface
- N, 16, data/twiddle word width (signed two's complement)
- Q, 8, fractional bits; 1.0 = 2^Q
- TAG_W, 4, width of pass-through tag
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept (= pipeline enable)
- i_in0_re, i_in0_im, i_in1_re, i_in1_im  in  N each  input operands
- i_twiddle_re, i_twiddle_im  in  N each  W^nk
- i_inverse  in  1  1: use conj(W) (IFFT); sampled with the beat
- i_scale  in  1  1: divide both outputs by 2; sampled with the beat
- i_tag  in  TAG_W  user tag, returned with result
- i_ready  in  1  downstream accepts
- o_valid  out  1  result valid
- o_out0_re, o_out0_im, o_out1_re, o_out1_im  out  N each  results
- o_tag  out  TAG_W  tag of the current result
- i_clr_ovf  in  1  synchronous clear of o_ovf
- o_ovf  out  1  sticky: any output saturated since reset/clear

## Operation
- Pipeline enable en = !o_valid | i_ready; o_ready = en. A beat is accepted when i_valid & en. All stage registers, including valid bits, advance only when en = 1.
- S1: register operands, tag, scale. If i_inverse, twiddle_im := −twiddle_im, saturating (−2^(N−1) → 2^(N−1)−1).
- S2: four full-precision 2N-bit products rr = in1_re·w_re, ii = in1_im·w_im, ri = in1_re·w_im, ir = in1_im·w_re. in0 and side-band data are delayed in step.
- S3: t_re = rr − ii, t_im = ri + ir (2N+1 bits). Round half-up: add 2^(Q−1), then arithmetic shift right by Q. in0 is sign-extended to match.
- S4: s0 = in0 + t, s1 = in0 − t at full width. If scale: s = (s + 1) >>> 1. Saturate each component to [−2^(N−1), 2^(N−1)−1]. Register the outputs.
- o_ovf sets on any saturating component of an output beat that is registered with en = 1. If i_clr_ovf and a new saturation occur in the same cycle, set wins. i_clr_ovf is honoured regardless of en.
- Mode and scale travel with each beat, so changing them between beats is legal with no flush.

## Timing
- Latency: 4 enabled cycles from acceptance to o_valid. Throughput: 1 beat/cycle when i_ready = 1.
- Stall: when o_valid & !i_ready, every register holds. Outputs stay stable and no beat is lost or duplicated.
- Reset (i_rst = 0, any time, including mid-stream): all valid bits, outputs, o_tag and o_ovf go to 0 immediately. o_ready = 1 after reset. In-flight beats are discarded.
- Bubbles (i_valid = 0) propagate as o_valid = 0 and do not disturb the output data registers' valid pairing.
- o_valid depends only on registers; o_ready is combinational from o_valid and i_ready.

## Test plan
(N=16, Q=8)
- **Unity twiddle:** in0=(256,0), in1=(256,0), W=(256,0), tag=5 → 4 cycles later o_out0=(512,0), o_out1=(0,0), o_tag=5, o_ovf=0.
- **−j twiddle, forward vs inverse:** in0=(256,0), in1=(256,0), W=(0,−256).
  - i_inverse=0 → out0=(256,−256), out1=(256,256).
  - i_inverse=1 → out0=(256,256), out1=(256,−256).
  - Alternate the mode every beat and check each result.
- **Scale and rounding:**
  - in0=(512,0), in1=(256,0), W=(256,0), scale=1 → out0=(384,0), out1=(128,0).
  - in1=(1,0), W=(128,0), in0=0 → out0=(1,0), out1=(−1,0).
- **Saturation:** in0=(32767,0), in1=(256,0), W=(256,0) → out0=(32767,0), out1=(32511,0), o_ovf=1 and stays 1. Pulsing i_clr_ovf → 0.
- **Backpressure:** stream 8 beats with incrementing tags while toggling i_ready randomly (including 5-cycle lows) → all 8 results appear in order, exactly once, and outputs are stable while stalled.
- **Reset mid-stream:** assert i_rst low for 1 cycle with 3 beats in flight → o_valid=0 and outputs 0 at once. The next accepted beat emerges after exactly 4 cycles with a correct result.

Source files
------------

// File: rtl/butterfly2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : butterfly2_pipe
// Brief    : 4-stage radix-2 DIT butterfly with stall, conj twiddle, /2 scaling,
//            output saturation and sticky overflow.
// Revision : 1.0
// ============================================================================
module butterfly2_pipe #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int TAG_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [N-1:0] i_in0_re,
  input  logic signed [N-1:0] i_in0_im,
  input  logic signed [N-1:0] i_in1_re,
  input  logic signed [N-1:0] i_in1_im,
  input  logic signed [N-1:0] i_twiddle_re,
  input  logic signed [N-1:0] i_twiddle_im,
  input  logic                i_inverse,
  input  logic                i_scale,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic                i_ready,
  output logic                o_valid,
  output logic signed [N-1:0] o_out0_re,
  output logic signed [N-1:0] o_out0_im,
  output logic signed [N-1:0] o_out1_re,
  output logic signed [N-1:0] o_out1_im,
  output logic [TAG_W-1:0]    o_tag,
  input  logic                i_clr_ovf,
  output logic                o_ovf
);

  localparam int c_PW = 2*N;
  localparam int c_TW = 2*N + 1;
  localparam int c_SW = 2*N + 2;
  localparam logic signed [N-1:0]    c_WMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]    c_WMIN = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [c_TW-1:0] c_HALF = {{(c_TW-1){1'b0}}, 1'b1} << (Q-1);
  localparam logic signed [c_SW-1:0] c_ONE  = {{(c_SW-1){1'b0}}, 1'b1};
  localparam logic signed [c_SW-1:0] c_SMAX = {{(c_SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [c_SW-1:0] c_SMIN = {{(c_SW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic w_en;
  logic r4_valid;

  assign w_en    = !r4_valid || i_ready;
  assign o_ready = w_en;
  assign o_valid = r4_valid;

  // Conjugate for inverse mode; negating the most negative value saturates.
  logic signed [N-1:0] w_wim_sel;
  always_comb begin
    w_wim_sel = i_twiddle_im;
    if (i_inverse) begin
      w_wim_sel = (i_twiddle_im == c_WMIN) ? c_WMAX : -i_twiddle_im;
    end
  end

  // ---------------- S1: operand capture ----------------
  logic                r1_valid, r1_scale;
  logic signed [N-1:0] r1_in0_re, r1_in0_im, r1_in1_re, r1_in1_im, r1_w_re, r1_w_im;
  logic [TAG_W-1:0]    r1_tag;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r1_valid  <= 1'b0;
      r1_scale  <= 1'b0;
      r1_in0_re <= '0;
      r1_in0_im <= '0;
      r1_in1_re <= '0;
      r1_in1_im <= '0;
      r1_w_re   <= '0;
      r1_w_im   <= '0;
      r1_tag    <= '0;
    end else if (w_en) begin
      r1_valid  <= i_valid;
      r1_scale  <= i_scale;
      r1_in0_re <= i_in0_re;
      r1_in0_im <= i_in0_im;
      r1_in1_re <= i_in1_re;
      r1_in1_im <= i_in1_im;
      r1_w_re   <= i_twiddle_re;
      r1_w_im   <= w_wim_sel;
      r1_tag    <= i_tag;
    end
  end

  // ---------------- S2: full-precision products ----------------
  logic                   r2_valid, r2_scale;
  logic signed [c_PW-1:0] r2_rr, r2_ii, r2_ri, r2_ir;
  logic signed [N-1:0]    r2_in0_re, r2_in0_im;
  logic [TAG_W-1:0]       r2_tag;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r2_valid  <= 1'b0;
      r2_scale  <= 1'b0;
      r2_rr     <= '0;
      r2_ii     <= '0;
      r2_ri     <= '0;
      r2_ir     <= '0;
      r2_in0_re <= '0;
      r2_in0_im <= '0;
      r2_tag    <= '0;
    end else if (w_en) begin
      r2_valid  <= r1_valid;
      r2_scale  <= r1_scale;
      r2_rr     <= r1_in1_re * r1_w_re;
      r2_ii     <= r1_in1_im * r1_w_im;
      r2_ri     <= r1_in1_re * r1_w_im;
      r2_ir     <= r1_in1_im * r1_w_re;
      r2_in0_re <= r1_in0_re;
      r2_in0_im <= r1_in0_im;
      r2_tag    <= r1_tag;
    end
  end

  // ---------------- S3: complex combine, round half-up, rescale by 2^Q ----------------
  logic signed [c_TW-1:0] w_tre_full, w_tim_full, w_t_re, w_t_im;

  assign w_tre_full = $signed({r2_rr[c_PW-1], r2_rr}) - $signed({r2_ii[c_PW-1], r2_ii}) + c_HALF;
  assign w_tim_full = $signed({r2_ri[c_PW-1], r2_ri}) + $signed({r2_ir[c_PW-1], r2_ir}) + c_HALF;
  assign w_t_re     = w_tre_full >>> Q;
  assign w_t_im     = w_tim_full >>> Q;

  logic                   r3_valid, r3_scale;
  logic signed [c_TW-1:0] r3_t_re, r3_t_im, r3_in0_re, r3_in0_im;
  logic [TAG_W-1:0]       r3_tag;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r3_valid  <= 1'b0;
      r3_scale  <= 1'b0;
      r3_t_re   <= '0;
      r3_t_im   <= '0;
      r3_in0_re <= '0;
      r3_in0_im <= '0;
      r3_tag    <= '0;
    end else if (w_en) begin
      r3_valid  <= r2_valid;
      r3_scale  <= r2_scale;
      r3_t_re   <= w_t_re;
      r3_t_im   <= w_t_im;
      r3_in0_re <= {{(N+1){r2_in0_re[N-1]}}, r2_in0_re};
      r3_in0_im <= {{(N+1){r2_in0_im[N-1]}}, r2_in0_im};
      r3_tag    <= r2_tag;
    end
  end

  // ---------------- S4: add/sub, optional /2, saturate ----------------
  logic signed [c_SW-1:0] w_sum [4];
  logic [N-1:0]           w_res [4];
  logic [3:0]             w_satf;

  assign w_sum[0] = $signed({r3_in0_re[c_TW-1], r3_in0_re}) + $signed({r3_t_re[c_TW-1], r3_t_re});
  assign w_sum[1] = $signed({r3_in0_im[c_TW-1], r3_in0_im}) + $signed({r3_t_im[c_TW-1], r3_t_im});
  assign w_sum[2] = $signed({r3_in0_re[c_TW-1], r3_in0_re}) - $signed({r3_t_re[c_TW-1], r3_t_re});
  assign w_sum[3] = $signed({r3_in0_im[c_TW-1], r3_in0_im}) - $signed({r3_t_im[c_TW-1], r3_t_im});

  for (genvar g = 0; g < 4; g++) begin : g_sat
    logic signed [c_SW-1:0] w_scaled;
    logic                   w_hi, w_lo;
    assign w_scaled  = r3_scale ? ((w_sum[g] + c_ONE) >>> 1) : w_sum[g];
    assign w_hi      = (w_scaled > c_SMAX);
    assign w_lo      = (w_scaled < c_SMIN);
    assign w_satf[g] = w_hi || w_lo;
    assign w_res[g]  = w_hi ? c_SMAX[N-1:0] : (w_lo ? c_SMIN[N-1:0] : w_scaled[N-1:0]);
  end

  logic [N-1:0]     r4_out [4];
  logic [TAG_W-1:0] r4_tag;
  logic             r_ovf;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r4_valid <= 1'b0;
      r4_tag   <= '0;
      for (int k = 0; k < 4; k++) r4_out[k] <= '0;
    end else if (w_en) begin
      r4_valid <= r3_valid;
      r4_tag   <= r3_tag;
      for (int k = 0; k < 4; k++) r4_out[k] <= w_res[k];
    end
  end

  // A new saturation takes priority over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_en && r3_valid && (|w_satf)) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_out0_re = r4_out[0];
  assign o_out0_im = r4_out[1];
  assign o_out1_re = r4_out[2];
  assign o_out1_im = r4_out[3];
  assign o_tag     = r4_tag;
  assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_butterfly2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_butterfly2_pipe
// Brief    : Directed vector bench for butterfly2_pipe (N=16, Q=8).
// Revision : 1.0
// ============================================================================
module tb_butterfly2_pipe;

  localparam int N = 16;
  localparam int T = 4;
  localparam int NV = 10;

  typedef struct {
    logic signed [N-1:0] a0r, a0i, a1r, a1i, wr, wi;
    logic                inv, sc;
    logic signed [N-1:0] e0r, e0i, e1r, e1i;
  } vec_t;

  typedef struct {
    logic [T-1:0]        tag;
    logic signed [N-1:0] e0r, e0i, e1r, e1i;
  } exp_t;

  logic                clk = 1'b0;
  logic                i_rst = 1'b0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic signed [N-1:0] i_in0_re = '0, i_in0_im = '0, i_in1_re = '0, i_in1_im = '0;
  logic signed [N-1:0] i_twiddle_re = '0, i_twiddle_im = '0;
  logic                i_inverse = 1'b0, i_scale = 1'b0;
  logic [T-1:0]        i_tag = '0;
  logic                i_ready = 1'b1;
  logic                o_valid;
  logic signed [N-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;
  logic [T-1:0]        o_tag;
  logic                i_clr_ovf = 1'b0;
  logic                o_ovf;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vt [NV];
  exp_t exp_q [$];
  logic bp_en = 1'b0;
  int   bp_cyc = 0;

  butterfly2_pipe #(.N(N), .Q(8), .TAG_W(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_in0_re(i_in0_re), .i_in0_im(i_in0_im), .i_in1_re(i_in1_re), .i_in1_im(i_in1_im),
    .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
    .i_inverse(i_inverse), .i_scale(i_scale), .i_tag(i_tag), .i_ready(i_ready),
    .o_valid(o_valid), .o_out0_re(o_out0_re), .o_out0_im(o_out0_im),
    .o_out1_re(o_out1_re), .o_out1_im(o_out1_im), .o_tag(o_tag),
    .i_clr_ovf(i_clr_ovf), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  // Downstream ready: forced low 5 cycles out of every 12, random otherwise.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bp_cyc++;
      i_ready = ((bp_cyc % 12) < 5) ? 1'b0 : 1'($urandom_range(0, 1));
    end else begin
      i_ready = 1'b1;
    end
  end

  function automatic vec_t mk(int a0r, int a0i, int a1r, int a1i, int wr, int wi,
                              bit inv, bit sc, int e0r, int e0i, int e1r, int e1i);
    vec_t v;
    v.a0r = 16'(a0r); v.a0i = 16'(a0i); v.a1r = 16'(a1r); v.a1i = 16'(a1i);
    v.wr  = 16'(wr);  v.wi  = 16'(wi);  v.inv = inv;      v.sc  = sc;
    v.e0r = 16'(e0r); v.e0i = 16'(e0i); v.e1r = 16'(e1r); v.e1i = 16'(e1i);
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Result scoreboard plus stall-stability check, sampled on the falling edge.
  logic                   stall_prev = 1'b0;
  logic [4*N+T:0]         snap_prev = '0;
  always @(negedge clk) begin
    if (!i_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_chk++;
        if ({o_valid, o_tag, o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== snap_prev) begin
          n_fail++;
          $display("FAIL stall_stable: got %h, expected %h",
                   {o_valid, o_tag, o_out0_re, o_out0_im, o_out1_re, o_out1_im}, snap_prev);
        end
      end
      if (o_valid && i_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got tag=%0d, expected no result", o_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (o_tag !== e.tag || o_out0_re !== e.e0r || o_out0_im !== e.e0i ||
              o_out1_re !== e.e1r || o_out1_im !== e.e1i) begin
            n_fail++;
            $display("FAIL result: got tag=%0d out0=(%0d,%0d) out1=(%0d,%0d), expected tag=%0d out0=(%0d,%0d) out1=(%0d,%0d)",
                     o_tag, o_out0_re, o_out0_im, o_out1_re, o_out1_im,
                     e.tag, e.e0r, e.e0i, e.e1r, e.e1i);
          end
        end
      end
      stall_prev = o_valid && !i_ready;
      snap_prev  = {o_valid, o_tag, o_out0_re, o_out0_im, o_out1_re, o_out1_im};
    end
  end

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send(input vec_t v, input logic [T-1:0] tag);
    exp_t e;
    int   guard;
    guard = 0;
    i_in0_re = v.a0r; i_in0_im = v.a0i; i_in1_re = v.a1r; i_in1_im = v.a1i;
    i_twiddle_re = v.wr; i_twiddle_im = v.wi;
    i_inverse = v.inv; i_scale = v.sc; i_tag = tag; i_valid = 1'b1;
    e.tag = tag; e.e0r = v.e0r; e.e0i = v.e0i; e.e1r = v.e1r; e.e1i = v.e1i;
    exp_q.push_back(e);
    while (1) begin
      @(negedge clk);
      if (o_ready) break;
      guard++;
      if (guard > 500) begin
        n_fail++;
        $display("FAIL send_timeout: got o_ready=0 for %0d cycles, expected acceptance", guard);
        $fatal(1, "input never accepted");
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk);
      #2;
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Call immediately after send() into an empty pipeline.
  task automatic latency(input string name);
    int lat;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(name, lat, 4);
  endtask

  initial begin
    vt[0] = mk(256, 0, 256, 0, 256, 0, 0, 0, 512, 0, 0, 0);
    vt[1] = mk(256, 0, 256, 0, 0, -256, 0, 0, 256, -256, 256, 256);
    vt[2] = mk(256, 0, 256, 0, 0, -256, 1, 0, 256, 256, 256, -256);
    vt[3] = mk(512, 0, 256, 0, 256, 0, 0, 1, 384, 0, 128, 0);
    vt[4] = mk(0, 0, 1, 0, 128, 0, 0, 0, 1, 0, -1, 0);
    vt[5] = mk(32767, 0, 256, 0, 256, 0, 0, 0, 32767, 0, 32511, 0);
    vt[6] = mk(100, -50, 300, 200, 128, -128, 0, 0, 350, -100, -150, 0);
    vt[7] = mk(0, 0, 0, 256, 0, -32768, 1, 0, -32767, 0, 32767, 0);
    vt[8] = mk(-3, 5, 0, 0, 256, 0, 0, 1, -1, 3, -1, 3);
    vt[9] = mk(-32768, 0, 256, 0, 256, 0, 0, 0, -32512, 0, -32768, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ovf", o_ovf, 0);
    chk("rst_o_out0_re", o_out0_re, 0);
    chk("rst_o_tag", o_tag, 0);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_o_ready", o_ready, 1);

    send(vt[0], 4'd5);
    latency("unity_latency");
    drain();
    chk("unity_ovf", o_ovf, 0);

    for (int i = 0; i < NV; i++) send(vt[i], 4'(i));
    for (int k = 0; k < 6; k++) send(vt[1 + (k % 2)], 4'(10 + k));
    drain();

    chk("ovf_set_by_table", o_ovf, 1);
    send(vt[6], 4'd3);
    drain();
    chk("ovf_sticky", o_ovf, 1);
    i_clr_ovf = 1'b1;
    @(posedge clk);
    #1 i_clr_ovf = 1'b0;
    chk("ovf_cleared", o_ovf, 0);
    send(vt[5], 4'd7);
    drain();
    chk("ovf_resat", o_ovf, 1);

    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) send(vt[(i < 5) ? i : i + 1], 4'(i));
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) send(vt[i], 4'(8 + i));
    chk("pre_reset_valid", o_valid, 1);
    #1 i_rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_out0_re", o_out0_re, 0);
    chk("midrst_o_out1_im", o_out1_im, 0);
    chk("midrst_o_tag", o_tag, 0);
    chk("midrst_o_ovf", o_ovf, 0);
    chk("midrst_o_ready", o_ready, 1);
    @(posedge clk);
    #2 i_rst = 1'b1;
    send(vt[6], 4'd9);
    latency("post_reset_latency");
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle_valid", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
